// File: rtl/memory_arbiter_pkg.sv
// Shared types and reset values for the instruction/data memory port arbiter.
// Slot and register structs are sized by ARB_XLEN.
package memory_arbiter_pkg;

    localparam int ARB_XLEN = 32;
    localparam int ARB_SLEN = ARB_XLEN / 8;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_type;

    typedef struct packed {
        logic                valid;
        logic                fence;
        logic [ARB_XLEN-1:0] addr;
        logic [ARB_XLEN-1:0] wdata;
        logic [ARB_SLEN-1:0] wstrb;
    } arb_slot_type;

    typedef struct packed {
        arb_state_type state;
        logic          last_grant;
        arb_slot_type  islot;
        arb_slot_type  dslot;
    } arb_reg_type;

    localparam arb_slot_type init_arb_slot = '{
        valid: 1'b0,
        fence: 1'b0,
        addr:  {ARB_XLEN{1'b0}},
        wdata: {ARB_XLEN{1'b0}},
        wstrb: {ARB_SLEN{1'b0}}
    };

    localparam arb_reg_type init_arb_reg = '{
        state:      IDLE,
        last_grant: GRANT_I,
        islot:      init_arb_slot,
        dslot:      init_arb_slot
    };

    function automatic arb_slot_type make_slot(
        input logic                fence,
        input logic [ARB_XLEN-1:0] addr,
        input logic [ARB_XLEN-1:0] wdata,
        input logic [ARB_SLEN-1:0] wstrb
    );
        arb_slot_type s;
        s.valid = 1'b1;
        s.fence = fence;
        s.addr  = addr;
        s.wdata = wdata;
        s.wstrb = wstrb;
        return s;
    endfunction

endpackage

// File: rtl/memory_arbiter_checker.sv
// Protocol checks for the memory arbiter's requester interfaces.
// The data requester must wait for dmem_ready before raising dmem_valid again.
module memory_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic dmem_valid,
    input logic d_busy
);

    // A data request while the previous one is still pending or in flight is dropped by the arbiter.
    data_one_outstanding: assert property (@(posedge clk) disable iff (!rst) !(dmem_valid && d_busy));

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction prefetch and the load/store unit.
// One transaction in flight; each requester may park one blocked request in its slot.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int XLEN      = ARB_XLEN,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid,
    input  logic              imem_fence,
    input  logic [XLEN-1:0]   imem_addr,
    output logic              imem_ready,
    output logic [XLEN-1:0]   imem_rdata,
    input  logic              dmem_valid,
    input  logic              dmem_fence,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wstrb,
    output logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_valid,
    output logic              mem_fence,
    output logic              mem_instr,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_reg_type  r;
    arb_reg_type  rin;
    arb_slot_type icand_s;
    arb_slot_type dcand_s;
    logic         d_busy_s;
    logic         d_live_s;
    logic         i_want_s;
    logic         d_want_s;
    logic         can_issue_s;
    logic         grant_i_s;
    logic         grant_d_s;

    // Arbitration, slot capture, next state and the zero-latency bus/response outputs.
    always_comb begin
        rin = r;

        icand_s = r.islot.valid ? r.islot
                                : make_slot(imem_fence, imem_addr, {ARB_XLEN{1'b0}}, {ARB_SLEN{1'b0}});
        dcand_s = r.dslot.valid ? r.dslot
                                : make_slot(dmem_fence, dmem_addr, dmem_wdata, dmem_wstrb);

        // The data requester counts as busy until its response cycle; a request then is dropped.
        d_busy_s    = r.dslot.valid | ((r.state == BUSY_D) & ~mem_ready);
        d_live_s    = dmem_valid & ~d_busy_s;
        i_want_s    = r.islot.valid | imem_valid;
        d_want_s    = r.dslot.valid | d_live_s;
        can_issue_s = (r.state == IDLE) | mem_ready;

        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (can_issue_s && i_want_s && d_want_s) begin
            if ((DATA_PRIO == 1'b1) || (r.last_grant == GRANT_I)) begin
                grant_d_s = 1'b1;
            end else begin
                grant_i_s = 1'b1;
            end
        end else if (can_issue_s && i_want_s) begin
            grant_i_s = 1'b1;
        end else if (can_issue_s && d_want_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end

        // A live instr request that is not issued always lands in the slot, so the newest address wins.
        if (imem_valid && !(grant_i_s && !r.islot.valid)) begin
            rin.islot = make_slot(imem_fence, imem_addr, {ARB_XLEN{1'b0}}, {ARB_SLEN{1'b0}});
        end else if (grant_i_s) begin
            rin.islot = init_arb_slot;
        end else begin
            rin.islot = r.islot;
        end

        if (d_live_s && !grant_d_s) begin
            rin.dslot = make_slot(dmem_fence, dmem_addr, dmem_wdata, dmem_wstrb);
        end else if (grant_d_s) begin
            rin.dslot = init_arb_slot;
        end else begin
            rin.dslot = r.dslot;
        end

        if (grant_i_s) begin
            rin.state      = BUSY_I;
            rin.last_grant = GRANT_I;
        end else if (grant_d_s) begin
            rin.state      = BUSY_D;
            rin.last_grant = GRANT_D;
        end else if (can_issue_s) begin
            rin.state = IDLE;
        end else begin
            rin.state = r.state;
        end

        mem_valid = grant_i_s | grant_d_s;
        mem_instr = grant_i_s;
        if (grant_i_s) begin
            mem_fence = icand_s.fence;
            mem_addr  = icand_s.addr;
            mem_wdata = {XLEN{1'b0}};
            mem_wstrb = {(XLEN/8){1'b0}};
        end else if (grant_d_s) begin
            mem_fence = dcand_s.fence;
            mem_addr  = dcand_s.addr;
            mem_wdata = dcand_s.wdata;
            mem_wstrb = dcand_s.wstrb;
        end else begin
            mem_fence = 1'b0;
            mem_addr  = {XLEN{1'b0}};
            mem_wdata = {XLEN{1'b0}};
            mem_wstrb = {(XLEN/8){1'b0}};
        end

        // A response seen in IDLE is stale and goes nowhere.
        imem_ready = (r.state == BUSY_I) & mem_ready;
        dmem_ready = (r.state == BUSY_D) & mem_ready;
        imem_rdata = mem_rdata;
        dmem_rdata = mem_rdata;

        if (!rst) begin
            rin        = init_arb_reg;
            mem_valid  = 1'b0;
            mem_instr  = 1'b0;
            mem_fence  = 1'b0;
            mem_addr   = {XLEN{1'b0}};
            mem_wdata  = {XLEN{1'b0}};
            mem_wstrb  = {(XLEN/8){1'b0}};
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            imem_rdata = {XLEN{1'b0}};
            dmem_rdata = {XLEN{1'b0}};
        end else begin
            rin = rin;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= init_arb_reg;
        end else begin
            r <= rin;
        end
    end

    memory_arbiter_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .dmem_valid (dmem_valid),
        .d_busy     (d_busy_s)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: a data-priority and a round-robin arbiter side by side,
// each compared cycle by cycle against a request-level reference model.
module tb_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv[2], ifn[2], ir[2], dv[2], dfn[2], dr[2];
    logic        mv[2], mf[2], mi[2], mr[2];
    logic [31:0] ia[2], ird[2], da[2], dw[2], drd[2], ma[2], mw[2];
    logic [3:0]  ds[2], ms[2];
    logic [31:0] mrd;

    memory_arbiter #(.XLEN(32), .DATA_PRIO(1'b1)) dut_dp (
        .clk(clk), .rst(rst),
        .imem_valid(iv[0]), .imem_fence(ifn[0]), .imem_addr(ia[0]), .imem_ready(ir[0]), .imem_rdata(ird[0]),
        .dmem_valid(dv[0]), .dmem_fence(dfn[0]), .dmem_addr(da[0]), .dmem_wdata(dw[0]), .dmem_wstrb(ds[0]),
        .dmem_ready(dr[0]), .dmem_rdata(drd[0]),
        .mem_valid(mv[0]), .mem_fence(mf[0]), .mem_instr(mi[0]), .mem_addr(ma[0]), .mem_wdata(mw[0]),
        .mem_wstrb(ms[0]), .mem_ready(mr[0]), .mem_rdata(mrd)
    );

    memory_arbiter #(.XLEN(32), .DATA_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .imem_valid(iv[1]), .imem_fence(ifn[1]), .imem_addr(ia[1]), .imem_ready(ir[1]), .imem_rdata(ird[1]),
        .dmem_valid(dv[1]), .dmem_fence(dfn[1]), .dmem_addr(da[1]), .dmem_wdata(dw[1]), .dmem_wstrb(ds[1]),
        .dmem_ready(dr[1]), .dmem_rdata(drd[1]),
        .mem_valid(mv[1]), .mem_fence(mf[1]), .mem_instr(mi[1]), .mem_addr(ma[1]), .mem_wdata(mw[1]),
        .mem_wstrb(ms[1]), .mem_ready(mr[1]), .mem_rdata(mrd)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bus owner 0=none 1=instr 2=data, one parked request per requester.
    int          owner[2], last[2], mem_wait[2];
    bit          pi_v[2], pi_f[2], pd_v[2], pd_f[2], d_out[2];
    logic [31:0] pi_a[2], pd_a[2], pd_w[2];
    logic [3:0]  pd_s[2];

    bit mr_manual = 1'b0;
    bit stale_en  = 1'b0;
    bit rand_rdata = 1'b0;
    int lat_lo = 1, lat_hi = 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        owner[k] = 0; last[k] = 1; mem_wait[k] = 0;
        pi_v[k] = 1'b0; pd_v[k] = 1'b0; d_out[k] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ifn[k] = 1'b0; dv[k] = 1'b0; dfn[k] = 1'b0;
        end
    endtask

    task automatic req_i(input logic [31:0] a, input bit f);
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; ia[k] = a; ifn[k] = f;
        end
    endtask

    task automatic req_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, input bit f);
        for (int k = 0; k < 2; k++) begin
            dv[k] = 1'b1; da[k] = a; dw[k] = w; ds[k] = s; dfn[k] = f; d_out[k] = 1'b1;
        end
    endtask

    // Memory responder, then sample at the falling edge and compare against the model.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (!mr_manual) begin
                if (owner[k] != 0) begin
                    if (mem_wait[k] == 0) mr[k] = 1'b1;
                    else begin mr[k] = 1'b0; mem_wait[k]--; end
                end else begin
                    mr[k] = stale_en && ($urandom_range(0, 7) == 0);
                end
            end
        end
        mrd = rand_rdata ? $urandom : 32'h0000_0013;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int g;
            bit ic, dc, can, eir, edr, ef;
            logic [31:0] ea, ew;
            logic [3:0]  es;
            if (!rst) begin
                check_eq($sformatf("rst_mem_valid%0d", k), mv[k], 32'd0);
                check_eq($sformatf("rst_mem_addr%0d", k), ma[k], 32'd0);
                check_eq($sformatf("rst_imem_ready%0d", k), ir[k], 32'd0);
                check_eq($sformatf("rst_dmem_ready%0d", k), dr[k], 32'd0);
                check_eq($sformatf("rst_rdata%0d", k), ird[k], 32'd0);
                model_reset(k);
            end else begin
                ic  = pi_v[k] || iv[k];
                dc  = pd_v[k] || dv[k];
                can = (owner[k] == 0) || mr[k];
                g = 0;
                if (can && ic && dc) g = (k == 0) ? 2 : ((last[k] == 2) ? 1 : 2);
                else if (can && ic) g = 1;
                else if (can && dc) g = 2;
                eir = (owner[k] == 1) && mr[k];
                edr = (owner[k] == 2) && mr[k];
                ef = 1'b0; ea = 32'd0; ew = 32'd0; es = 4'd0;
                if (g == 1) begin
                    ef = pi_v[k] ? pi_f[k] : ifn[k];
                    ea = pi_v[k] ? pi_a[k] : ia[k];
                end else if (g == 2) begin
                    ef = pd_v[k] ? pd_f[k] : dfn[k];
                    ea = pd_v[k] ? pd_a[k] : da[k];
                    ew = pd_v[k] ? pd_w[k] : dw[k];
                    es = pd_v[k] ? pd_s[k] : ds[k];
                end
                check_eq($sformatf("mem_valid%0d", k), mv[k], (g != 0) ? 32'd1 : 32'd0);
                check_eq($sformatf("mem_fence%0d", k), mf[k], ef);
                check_eq($sformatf("imem_ready%0d", k), ir[k], eir);
                check_eq($sformatf("dmem_ready%0d", k), dr[k], edr);
                check_eq($sformatf("imem_rdata%0d", k), ird[k], mrd);
                check_eq($sformatf("dmem_rdata%0d", k), drd[k], mrd);
                if (g != 0) begin
                    check_eq($sformatf("mem_instr%0d", k), mi[k], (g == 1) ? 32'd1 : 32'd0);
                    check_eq($sformatf("mem_addr%0d", k), ma[k], ea);
                    check_eq($sformatf("mem_wdata%0d", k), mw[k], ew);
                    check_eq($sformatf("mem_wstrb%0d", k), ms[k], es);
                end
                if (iv[k] && !(g == 1 && !pi_v[k])) begin
                    pi_v[k] = 1'b1; pi_a[k] = ia[k]; pi_f[k] = ifn[k];
                end else if (g == 1) pi_v[k] = 1'b0;
                if (dv[k] && !(g == 2 && !pd_v[k])) begin
                    pd_v[k] = 1'b1; pd_a[k] = da[k]; pd_w[k] = dw[k]; pd_s[k] = ds[k]; pd_f[k] = dfn[k];
                end else if (g == 2) pd_v[k] = 1'b0;
                if (g != 0) begin
                    owner[k] = g; last[k] = g;
                    mem_wait[k] = $urandom_range(lat_lo, lat_hi);
                end else if (can) owner[k] = 0;
                if (edr) d_out[k] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin next_cycle(); step(); end
    endtask

    initial begin
        rst = 1'b0; mrd = 32'd0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ifn[k] = 1'b0; ia[k] = 32'd0; dv[k] = 1'b0; dfn[k] = 1'b0;
            da[k] = 32'd0; dw[k] = 32'd0; ds[k] = 4'd0; mr[k] = 1'b0;
            model_reset(k);
        end
        drain(3);
        rst = 1'b1;

        // Single instruction fetch, response two cycles after issue.
        next_cycle(); req_i(32'h100, 1'b0); step();
        check_eq("t1_valid", mv[0], 32'd1);
        check_eq("t1_instr", mi[0], 32'd1);
        drain(1);
        next_cycle(); step();
        check_eq("t1_iready", ir[0], 32'd1);
        check_eq("t1_irdata", ird[0], 32'h13);
        check_eq("t1_dready", dr[0], 32'd0);

        // Simultaneous requests: data first, instr in the data response cycle.
        next_cycle(); req_i(32'h200, 1'b0); req_d(32'h8000, 32'h1234_5678, 4'hF, 1'b0); step();
        check_eq("t2_first_instr", mi[0], 32'd0);
        check_eq("t2_first_addr", ma[0], 32'h8000);
        drain(1);
        next_cycle(); step();
        check_eq("t2_b2b_valid", mv[0], 32'd1);
        check_eq("t2_b2b_addr", ma[0], 32'h200);
        check_eq("t2_b2b_dready", dr[0], 32'd1);
        drain(3);

        // Round-robin with last grant = data: instr wins.
        next_cycle(); req_d(32'h8004, 32'd0, 4'h0, 1'b0); step();
        drain(3);
        next_cycle(); req_i(32'h240, 1'b0); req_d(32'h8008, 32'hCAFE_0000, 4'h3, 1'b0); step();
        check_eq("t3_rr_instr", mi[1], 32'd1);
        check_eq("t3_rr_addr", ma[1], 32'h240);
        check_eq("t3_dp_addr", ma[0], 32'h8008);
        drain(6);

        // Instr redirect while data is busy: only the newest address issues.
        lat_lo = 3; lat_hi = 3;
        next_cycle(); req_d(32'h9000, 32'h5555_AAAA, 4'h1, 1'b0); step();
        lat_lo = 1; lat_hi = 1;
        next_cycle(); req_i(32'h300, 1'b0); step();
        next_cycle(); req_i(32'h400, 1'b0); step();
        drain(1);
        next_cycle(); step();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("t4_valid%0d", k), mv[k], 32'd1);
            check_eq($sformatf("t4_addr%0d", k), ma[k], 32'h400);
        end
        drain(4);

        // Reset during an instr transaction discards its response.
        next_cycle(); req_i(32'h500, 1'b0); step();
        next_cycle(); rst = 1'b0; step();
        next_cycle(); rst = 1'b1; mr_manual = 1'b1; mr[0] = 1'b1; mr[1] = 1'b1; step();
        check_eq("t5_iready", ir[0], 32'd0);
        check_eq("t5_valid", mv[0], 32'd0);
        mr_manual = 1'b0;
        drain(2);

        // Fence hint only on the issue cycle.
        next_cycle(); req_d(32'hA000, 32'd0, 4'h0, 1'b1); step();
        check_eq("t6_fence_issue", mf[0], 32'd1);
        next_cycle(); step();
        check_eq("t6_fence_after", mf[0], 32'd0);
        drain(3);

        // Randomized traffic with variable latency, stale responses and occasional reset.
        stale_en = 1'b1; rand_rdata = 1'b1; lat_lo = 0; lat_hi = 3;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 2; k++) begin
                if (!rst) begin
                    d_out[k] = 1'b0;
                end else begin
                    if ($urandom_range(0, 2) == 0) begin
                        iv[k] = 1'b1; ia[k] = $urandom & 32'hFFFF_FFFC; ifn[k] = ($urandom_range(0, 7) == 0);
                    end
                    if (!d_out[k] && $urandom_range(0, 2) == 0) begin
                        dv[k] = 1'b1; da[k] = $urandom; dw[k] = $urandom;
                        ds[k] = 4'($urandom_range(0, 15)); dfn[k] = ($urandom_range(0, 7) == 0);
                        d_out[k] = 1'b1;
                    end
                end
            end
            step();
        end
        rst = 1'b1;
        drain(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
